cpu_trace_buffer: RTL

Synthesizable retire-trace capture unit for the pipelined WISC CPU. Each cycle it samples the write-back and memory-stage commit signals (register write, load, store, halt), packs any activity into one trace entry, and stores it in a parametrised circular buffer. A valid/ready stream drains the buffer. Running cycle, instruction, overrun and drop counters provide the same statistics in hardware that the phase-2 simulation log produces, so traces can be taken on silicon/FPGA without the testbench.

---
 rtl/cpu_trace_buffer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// Retire-trace capture unit: packs WB/MEM commit activity into a circular buffer drained by a valid/ready stream.
// Optional build macro TRACE_CYCLE_STAMP_EN adds a per-entry cycle stamp reported on out_cycle.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | not capturing, counters hold, draining allowed
// RUN    | capturing commit activity, cycle_count running
// HALTED | halt captured; frozen until clr or reset

module cpu_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 32,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              wb_regwrite,
   input  logic [3:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_kind,
   output logic [3:0]        out_reg,
   output logic [DATA_W-1:0] out_reg_data,
   output logic [DATA_W-1:0] out_mem_addr,
   output logic [DATA_W-1:0] out_mem_data,
   output logic [CNT_W-1:0]  out_cycle,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  overrun_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic [1:0]        state,
   output logic              proto_err,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d, inst_q, inst_d, over_q, over_d, drop_q, drop_d;
   logic               perr_q, perr_d;

   logic [3:0]         kind_mem  [DEPTH];
   logic [3:0]         reg_mem   [DEPTH];
   logic [DATA_W-1:0]  rdata_mem [DEPTH];
   logic [DATA_W-1:0]  addr_mem  [DEPTH];
   logic [DATA_W-1:0]  mdata_mem [DEPTH];

   logic               capture, push, pop, write_en, overrun, dropped, adv_rd;
   logic               is_load;
   logic [3:0]         e_kind, e_reg;
   logic [DATA_W-1:0]  e_rdata, e_addr, e_mdata;

   assign capture  = (state_q == RUN) && (wb_regwrite || mem_read || mem_write || halt);
   assign push     = capture && !clr;
   assign pop      = out_valid && out_ready && !clr;
   assign overrun  = push && full && !pop && OVERWRITE;
   assign dropped  = push && full && !pop && !OVERWRITE;
   assign write_en = push && !dropped;
   assign adv_rd   = pop || overrun;

   // a simultaneous store wins over a load; the load flag is cleared
   assign is_load  = mem_read && !mem_write;
   assign e_kind   = {halt, mem_write, is_load, wb_regwrite};
   assign e_reg    = wb_regwrite ? wb_reg : 4'd0;
   assign e_rdata  = wb_regwrite ? wb_data : '0;
   assign e_addr   = (mem_read || mem_write) ? mem_addr : '0;
   assign e_mdata  = mem_write ? mem_wdata : (mem_read ? mem_rdata : '0);

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN: begin
               if (capture && halt) state_d = HALTED;
               else if (!en)        state_d = IDLE;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cycle_d  = cycle_q;
      inst_d   = inst_q;
      over_d   = over_q;
      drop_d   = drop_q;
      perr_d   = perr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         cycle_d  = '0;
         inst_d   = '0;
         over_d   = '0;
         drop_d   = '0;
         perr_d   = 1'b0;
      end else begin
         if (write_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (adv_rd)   rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (write_en && !adv_rd)      count_d = count_q + OCC_ONE;
         else if (adv_rd && !write_en) count_d = count_q - OCC_ONE;
         if (state_q == RUN) cycle_d = cycle_q + CNT_ONE;
         if (push && (wb_regwrite || mem_write || halt)) inst_d = inst_q + CNT_ONE;
         if (overrun) over_d = over_q + CNT_ONE;
         if (dropped) drop_d = drop_q + CNT_ONE;
         if (push && mem_read && mem_write) perr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cycle_q  <= '0;
         inst_q   <= '0;
         over_q   <= '0;
         drop_q   <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cycle_q  <= cycle_d;
         inst_q   <= inst_d;
         over_q   <= over_d;
         drop_q   <= drop_d;
         perr_q   <= perr_d;
      end
   end

   // storage is not reset; every read is gated by occupancy
   always_ff @(posedge clk) begin
      if (write_en) begin
         kind_mem[wr_ptr_q]  <= e_kind;
         reg_mem[wr_ptr_q]   <= e_reg;
         rdata_mem[wr_ptr_q] <= e_rdata;
         addr_mem[wr_ptr_q]  <= e_addr;
         mdata_mem[wr_ptr_q] <= e_mdata;
      end
   end

`ifdef TRACE_CYCLE_STAMP_EN
   logic [CNT_W-1:0] cyc_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_en) cyc_mem[wr_ptr_q] <= cycle_q;
   end

   assign out_cycle = out_valid ? cyc_mem[rd_ptr_q] : '0;
`else
   assign out_cycle = '0;
`endif

   assign out_valid     = (count_q != '0);
   assign empty         = (count_q == '0);
   assign full          = (count_q == FULL_CNT);
   assign out_kind      = out_valid ? kind_mem[rd_ptr_q]  : 4'd0;
   assign out_reg       = out_valid ? reg_mem[rd_ptr_q]   : 4'd0;
   assign out_reg_data  = out_valid ? rdata_mem[rd_ptr_q] : '0;
   assign out_mem_addr  = out_valid ? addr_mem[rd_ptr_q]  : '0;
   assign out_mem_data  = out_valid ? mdata_mem[rd_ptr_q] : '0;
   assign cycle_count   = cycle_q;
   assign inst_count    = inst_q;
   assign overrun_count = over_q;
   assign drop_count    = drop_q;
   assign state         = state_q;
   assign proto_err     = perr_q;

endmodule
